// File: rtl/seg_hex_scan.sv
// seg_hex_scan: scanned multi-digit hex driver for common-anode 7-segment displays.
// Holds a shadow copy of DIGITS nibbles plus dp/blank flags and lights one digit
// per slot of SCAN_DIV cycles, keeping all selects off for the first DEAD cycles.
// Optional feature: define SEG_LZ_SUPPRESS_EN to blank leading zero digits.
module seg_hex_scan #(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEAD     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     sel
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blank;
    logic [CW-1:0]       div_cnt;
    logic [IW-1:0]       idx;

    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic                cur_supp;
    logic [7:0]          seg_c;
    logic [DIGITS-1:0]   sel_c;

    // Active-low segment pattern g..a for one hex nibble
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Shadow registers: capture on load, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_data  <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
        end else if (load) begin
            sh_data  <= data;
            sh_dp    <= dp;
            sh_blank <= blank;
        end
    end

    // Slot divider and digit index; index steps on the last cycle of each slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == CW'(SCAN_DIV - 1)) begin
            div_cnt <= '0;
            idx     <= (idx == IW'(DIGITS - 1)) ? '0 : IW'(idx + 1'b1);
        end else begin
            div_cnt <= CW'(div_cnt + 1'b1);
        end
    end

    // Select the shadow fields of the current digit
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx == IW'(i)) begin
                cur_nib   = sh_data[4*i +: 4];
                cur_dp    = sh_dp[i];
                cur_blank = sh_blank[i];
            end
        end
    end

`ifdef SEG_LZ_SUPPRESS_EN
    logic [DIGITS-1:0] supp;
    logic              lead;

    // Blank zero digits (without dp) from the top down until the first significant one
    always_comb begin
        supp     = '0;
        lead     = 1'b1;
        cur_supp = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (lead && (sh_data[4*i +: 4] == 4'h0) && !sh_dp[i]) begin
                supp[i] = 1'b1;
            end else begin
                lead = 1'b0;
            end
        end
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx == IW'(i)) begin
                cur_supp = supp[i];
            end
        end
    end
`else
    assign cur_supp = 1'b0;
`endif

    // Next output decode: dark during dead time, digit select afterwards
    always_comb begin
        seg_c = 8'hFF;
        sel_c = '1;
        if (div_cnt >= CW'(DEAD)) begin
            sel_c = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx);
            if (!(cur_blank || cur_supp)) begin
                seg_c = {~cur_dp, hex7(cur_nib)};
            end
        end
    end

    // Registered pin drivers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= 8'hFF;
            sel <= '1;
        end else begin
            seg <= seg_c;
            sel <= sel_c;
        end
    end

endmodule

// File: tb/tb_seg_hex_scan.sv
// tb_seg_hex_scan: directed bench for seg_hex_scan (DIGITS=4, SCAN_DIV=8, DEAD=2).
// A cycle-count model predicts seg/sel every cycle; literal vectors pin the model.
// Honours SEG_LZ_SUPPRESS_EN the same way as the design.
module tb_seg_hex_scan;

    localparam int D  = 4;
    localparam int SD = 8;
    localparam int DT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic [7:0]  seg;
    logic [3:0]  sel;

    int          m_k;
    logic [15:0] m_data;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;
    int          n_chk = 0;
    int          n_pass = 0;

    seg_hex_scan #(.DIGITS(D), .SCAN_DIV(SD), .DEAD(DT)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .data  (data),
        .dp    (dp),
        .blank (blank),
        .seg   (seg),
        .sel   (sel)
    );

    always #5 clk = ~clk;

    // Full active-low code with dp off
    function automatic logic [7:0] digit_code(input logic [3:0] n);
        logic [7:0] c;
        case (n)
            4'h0: c = 8'hC0; 4'h1: c = 8'hF9; 4'h2: c = 8'hA4; 4'h3: c = 8'hB0;
            4'h4: c = 8'h99; 4'h5: c = 8'h92; 4'h6: c = 8'h82; 4'h7: c = 8'hF8;
            4'h8: c = 8'h80; 4'h9: c = 8'h90; 4'hA: c = 8'h88; 4'hB: c = 8'h83;
            4'hC: c = 8'hC6; 4'hD: c = 8'hA1; 4'hE: c = 8'h86; default: c = 8'h8E;
        endcase
        return c;
    endfunction

    // Expected {seg, sel} after edge number k (counted from reset release)
    function automatic logic [11:0] expect_out(input int k, input logic [15:0] d,
                                               input logic [3:0] p, input logic [3:0] b);
        int         slot;
        int         dig;
        int         top;
        bit         dark;
        logic [7:0] s;
        logic [3:0] e;
        slot = k % SD;
        dig  = (k / SD) % D;
        if (slot < DT) return {8'hFF, 4'hF};
        e = 4'hF;
        e[dig] = 1'b0;
        dark = b[dig];
`ifdef SEG_LZ_SUPPRESS_EN
        top = 0;
        for (int i = 0; i < D; i++) if (d[4*i +: 4] != 4'h0 || p[i]) top = i;
        if (dig > top) dark = 1'b1;
`else
        top = 0;
`endif
        s = digit_code(d[4*dig +: 4]);
        s[7] = ~p[dig];
        if (dark) s = 8'hFF;
        return {s, e};
    endfunction

    task automatic check(input string name, input logic [7:0] as, input logic [3:0] al,
                         input logic [7:0] es, input logic [3:0] el);
        n_chk++;
        if (as === es && al === el) n_pass++;
        else $display("FAIL %s: got seg=%h sel=%b, expected seg=%h sel=%b", name, as, al, es, el);
    endtask

    // Model: advance per edge and compare every cycle
    always @(posedge clk) begin
        logic [11:0] e;
        if (rst) begin
            m_k = 0;
            m_data = '0;
            m_dp = '0;
            m_blank = '0;
            e = {8'hFF, 4'hF};
        end else begin
            e = expect_out(m_k, m_data, m_dp, m_blank);
            if (load) begin
                m_data = data;
                m_dp = dp;
                m_blank = blank;
            end
            m_k++;
        end
        #1;
        check("model", seg, sel, e[11:4], e[3:0]);
    end

    // Wait at negedges until k edges have passed since reset release
    task automatic goto(input int k);
        int g;
        g = 0;
        while (m_k < k && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (m_k != k) begin
            n_chk++;
            $display("FAIL goto: at edge %0d, expected edge %0d", m_k, k);
        end
    endtask

    // Literal check of the outputs produced by edge k
    task automatic lit(input string name, input int k, input logic [7:0] es, input logic [3:0] el);
        goto(k + 1);
        check(name, seg, sel, es, el);
    endtask

    task automatic start(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        data = d;
        dp = p;
        blank = b;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Basic scan of 1234
        start(16'h1234, 4'b0000, 4'b0000);
        lit("d0_dead1", 1, 8'hFF, 4'b1111);
        lit("d0_lit", 2, 8'h99, 4'b1110);
        lit("d0_last", 7, 8'h99, 4'b1110);
        lit("d1_dead", 8, 8'hFF, 4'b1111);
        lit("d1_lit", 10, 8'hB0, 4'b1101);
        lit("d2_lit", 18, 8'hA4, 4'b1011);
        lit("d3_lit", 26, 8'hF9, 4'b0111);
        lit("period2_d0", 34, 8'h99, 4'b1110);

        // Letters and a decimal point
        start(16'hABCD, 4'b0010, 4'b0000);
        lit("abcd_d0", 2, 8'hA1, 4'b1110);
        lit("abcd_d1_dp", 10, 8'h46, 4'b1101);
        lit("abcd_d2", 18, 8'h83, 4'b1011);
        lit("abcd_d3", 26, 8'h88, 4'b0111);

        // Blanked digit still gets its select
        start(16'h1234, 4'b0000, 4'b0100);
        lit("blank_d1", 10, 8'hB0, 4'b1101);
        lit("blank_d2", 18, 8'hFF, 4'b1011);
        lit("blank_d3", 26, 8'hF9, 4'b0111);

        // Leading zeros
        start(16'h0050, 4'b0000, 4'b0000);
`ifdef SEG_LZ_SUPPRESS_EN
        lit("lz_d0", 2, 8'hC0, 4'b1110);
        lit("lz_d1", 10, 8'h92, 4'b1101);
        lit("lz_d2", 18, 8'hFF, 4'b1011);
        lit("lz_d3", 26, 8'hFF, 4'b0111);
`else
        lit("nolz_d1", 10, 8'h92, 4'b1101);
        lit("nolz_d2", 18, 8'hC0, 4'b1011);
        lit("nolz_d3", 26, 8'hC0, 4'b0111);
`endif
        start(16'h0000, 4'b0000, 4'b0000);
        lit("zero_d0", 2, 8'hC0, 4'b1110);
`ifdef SEG_LZ_SUPPRESS_EN
        lit("zero_d1", 10, 8'hFF, 4'b1101);
`else
        lit("zero_d1", 10, 8'hC0, 4'b1101);
`endif

        // Asynchronous reset in the middle of digit 2's slot
        start(16'h1234, 4'b0000, 4'b0000);
        lit("pre_rst_d2", 20, 8'hA4, 4'b1011);
        rst = 1'b1;
        #1;
        check("async_rst", seg, sel, 8'hFF, 4'b1111);
        @(negedge clk);
        rst = 1'b0;
        lit("rst_dead", 1, 8'hFF, 4'b1111);
        lit("rst_shadow0", 2, 8'hC0, 4'b1110);

        // Load on the wrap cycle of digit 1
        start(16'h1234, 4'b0000, 4'b0000);
        goto(15);
        data = 16'h5678;
        load = 1'b1;
        goto(16);
        load = 1'b0;
        check("wrap_old", seg, sel, 8'hB0, 4'b1101);
        lit("wrap_dead", 16, 8'hFF, 4'b1111);
        lit("wrap_new_d2", 18, 8'h82, 4'b1011);
        lit("wrap_new_d3", 26, 8'h92, 4'b0111);

        // Load held for two cycles: the later value wins
        goto(40);
        data = 16'h1111;
        load = 1'b1;
        goto(41);
        data = 16'h2222;
        goto(42);
        load = 1'b0;
        lit("held_d1", 42, 8'hA4, 4'b1101);
        lit("held_d2", 50, 8'hA4, 4'b1011);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
